// File: rtl/enigma_out_fmt.sv
// enigma_out_fmt: output formatter for the Enigma core.
// It buffers 5-bit letter indices in a FIFO and converts each one to uppercase
// ASCII ('A'+idx, or '?' for indices 26..31). A space follows every GROUP_LEN
// letters. The result is sent as a valid/ready byte stream to the UART TX.
// Optional feature: define ENIGMA_FMT_NEWLINE_EN to end every GROUPS_PER_LINE-th
// group with CR LF instead of the space.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_in, char_in   letter strobe and index from the core (no backpressure)
//   tx_data, tx_valid   registered ASCII byte and its valid flag
//   tx_ready            sink accepts the byte (transfer on tx_valid && tx_ready)
//   fifo_count          letters currently buffered
//   overflow            sticky, set when a letter is dropped on a full FIFO
module enigma_out_fmt #(
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned GROUP_LEN       = 5,
  parameter int unsigned GROUPS_PER_LINE = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [4:0]               char_in,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;

  // Elaboration-time parameter sanity check.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GROUP_LEN < 1 || GROUPS_PER_LINE < 1) begin : g_bad_cfg
    $error("enigma_out_fmt: illegal parameter combination");
  end

`ifdef ENIGMA_FMT_NEWLINE_EN
  localparam int unsigned LW = (GROUPS_PER_LINE > 1) ? $clog2(GROUPS_PER_LINE) : 1;
  typedef enum logic [2:0] {IDLE, CHAR, SEP, CR, LF} state_t;
  logic [LW-1:0] line, line_n;
`else
  typedef enum logic [2:0] {IDLE, CHAR, SEP} state_t;
`endif

  state_t        state, state_n;
  logic [7:0]    tx_data_n;
  logic          tx_valid_n;
  logic [GW-1:0] grp, grp_n;

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, non_empty, xfer;
  logic [7:0]    head_ascii;

  function automatic logic [7:0] to_ascii(input logic [4:0] idx);
    return (idx < 5'd26) ? (8'h41 + 8'(idx)) : 8'h3F;
  endfunction

  // Full and empty are judged on the registered (pre-edge) count.
  assign push       = valid_in && (fifo_count != CW'(DEPTH));
  assign non_empty  = (fifo_count != '0);
  assign xfer       = tx_valid && tx_ready;
  assign head_ascii = to_ascii(mem[rd_ptr]);

  // Letter storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= char_in;
  end

  // FIFO pointers, count and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (valid_in && !push) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
    end
  end

  // FSM and output register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      grp      <= '0;
`ifdef ENIGMA_FMT_NEWLINE_EN
      line     <= '0;
`endif
    end else begin
      state    <= state_n;
      tx_data  <= tx_data_n;
      tx_valid <= tx_valid_n;
      grp      <= grp_n;
`ifdef ENIGMA_FMT_NEWLINE_EN
      line     <= line_n;
`endif
    end
  end

  // Next-state logic; the output register only changes when empty or on a transfer.
  always_comb begin
    state_n    = state;
    tx_data_n  = tx_data;
    tx_valid_n = tx_valid;
    grp_n      = grp;
    pop        = 1'b0;
`ifdef ENIGMA_FMT_NEWLINE_EN
    line_n     = line;
`endif
    case (state)
      IDLE: begin
        if (non_empty) begin
          pop        = 1'b1;
          tx_data_n  = head_ascii;
          tx_valid_n = 1'b1;
          state_n    = CHAR;
        end
      end
      CHAR: begin
        if (xfer) begin
          if (grp == GW'(GROUP_LEN - 1)) begin
            grp_n = '0;
`ifdef ENIGMA_FMT_NEWLINE_EN
            if (line == LW'(GROUPS_PER_LINE - 1)) begin
              tx_data_n = 8'h0D;
              state_n   = CR;
            end else begin
              line_n    = line + LW'(1);
              tx_data_n = 8'h20;
              state_n   = SEP;
            end
`else
            tx_data_n = 8'h20;
            state_n   = SEP;
`endif
          end else begin
            grp_n = grp + GW'(1);
            if (non_empty) begin
              pop       = 1'b1;
              tx_data_n = head_ascii;
            end else begin
              tx_valid_n = 1'b0;
              state_n    = IDLE;
            end
          end
        end
      end
`ifdef ENIGMA_FMT_NEWLINE_EN
      CR: begin
        if (xfer) begin
          tx_data_n = 8'h0A;
          state_n   = LF;
        end
      end
      SEP, LF: begin
        if (xfer) begin
          if (state == LF) line_n = '0;
`else
      SEP: begin
        if (xfer) begin
`endif
          if (non_empty) begin
            pop       = 1'b1;
            tx_data_n = head_ascii;
            state_n   = CHAR;
          end else begin
            tx_valid_n = 1'b0;
            state_n    = IDLE;
          end
        end
      end
      default: begin
        tx_valid_n = 1'b0;
        state_n    = IDLE;
      end
    endcase
  end

endmodule
